// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared lane order, sizing defaults and emergency FSM states
package traffic_pkg;

    localparam int NUM_LANES = 8;
    localparam int CNT_W     = 8;
    localparam int EMG_HOLD  = 4;

    // Lane order shared with the intersection controller
    localparam int LANE_N2 = 0;
    localparam int LANE_N1 = 1;
    localparam int LANE_E2 = 2;
    localparam int LANE_E1 = 3;
    localparam int LANE_S2 = 4;
    localparam int LANE_S1 = 5;
    localparam int LANE_W2 = 6;
    localparam int LANE_W1 = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } emgState_e;

endpackage

// File: rtl/lane_sensor_hub_if.sv
// rtl/lane_sensor_hub_if.sv - sensor inputs and registered controller-facing outputs
interface lane_sensor_hub_if #(
    parameter int NUM_LANES = traffic_pkg::NUM_LANES,
    parameter int CNT_W     = traffic_pkg::CNT_W
);
    logic [NUM_LANES-1:0]       arrive;
    logic [NUM_LANES-1:0]       depart;
    logic [NUM_LANES-1:0]       pedButton;
    logic                       pedAck;
    logic [NUM_LANES-1:0]       emgReq;
    logic [NUM_LANES*CNT_W-1:0] laneCounts;
    logic                       pedSignal;
    logic                       emgSignal;
    logic [NUM_LANES-1:0]       emgLane;

    // master: sensors and controller side; slave: the hub
    modport master (
        output arrive, depart, pedButton, pedAck, emgReq,
        input  laneCounts, pedSignal, emgSignal, emgLane
    );
    modport slave (
        input  arrive, depart, pedButton, pedAck, emgReq,
        output laneCounts, pedSignal, emgSignal, emgLane
    );
endinterface

// File: rtl/lane_counter.sv
// rtl/lane_counter.sv - saturating up/down vehicle counter for one lane
module lane_counter #(
    parameter int CNT_W = traffic_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    output logic [CNT_W-1:0] count
);
    // Count up to all-ones, down to zero; simultaneous up and down cancel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (up && !down && (count != '1)) begin
            count <= count + CNT_W'(1);
        end else if (down && !up && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end
endmodule

// File: rtl/lane_sensor_hub.sv
// rtl/lane_sensor_hub.sv - lane counts, pedestrian latch and emergency arbitration; SENSOR_SYNC_EN adds input synchronizers
module lane_sensor_hub #(
    parameter int NUM_LANES = traffic_pkg::NUM_LANES,
    parameter int CNT_W     = traffic_pkg::CNT_W,
    parameter int EMG_HOLD  = traffic_pkg::EMG_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    lane_sensor_hub_if.slave bus
);
    import traffic_pkg::*;

    localparam int HOLD_W = (EMG_HOLD > 1) ? $clog2(EMG_HOLD) : 1;

    logic [NUM_LANES-1:0] arriveEff;
    logic [NUM_LANES-1:0] departEff;
    logic [NUM_LANES-1:0] pedEff;
    logic [NUM_LANES-1:0] emgEff;

`ifdef SENSOR_SYNC_EN
    logic [NUM_LANES-1:0] arriveS1, arriveS2, arriveS3;
    logic [NUM_LANES-1:0] departS1, departS2, departS3;
    logic [NUM_LANES-1:0] pedS1, pedS2, pedS3;
    logic [NUM_LANES-1:0] emgS1, emgS2;

    // Two-flop synchronizers plus a history flop for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arriveS1 <= '0; arriveS2 <= '0; arriveS3 <= '0;
            departS1 <= '0; departS2 <= '0; departS3 <= '0;
            pedS1    <= '0; pedS2    <= '0; pedS3    <= '0;
            emgS1    <= '0; emgS2    <= '0;
        end else begin
            arriveS1 <= bus.arrive;    arriveS2 <= arriveS1; arriveS3 <= arriveS2;
            departS1 <= bus.depart;    departS2 <= departS1; departS3 <= departS2;
            pedS1    <= bus.pedButton; pedS2    <= pedS1;    pedS3    <= pedS2;
            emgS1    <= bus.emgReq;    emgS2    <= emgS1;
        end
    end

    // A held sensor level counts once; emergency requests stay level-sensitive
    assign arriveEff = arriveS2 & ~arriveS3;
    assign departEff = departS2 & ~departS3;
    assign pedEff    = pedS2 & ~pedS3;
    assign emgEff    = emgS2;
`else
    assign arriveEff = bus.arrive;
    assign departEff = bus.depart;
    assign pedEff    = bus.pedButton;
    assign emgEff    = bus.emgReq;
`endif

    logic [CNT_W-1:0] laneCount [NUM_LANES];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_counter #(
            .CNT_W (CNT_W)
        ) u_lane_counter (
            .clk   (clk),
            .rst   (rst),
            .up    (arriveEff[i]),
            .down  (departEff[i]),
            .count (laneCount[i])
        );
        assign bus.laneCounts[i*CNT_W +: CNT_W] = laneCount[i];
    end

    logic pedReg;

    // Pending pedestrian request; a press in the ack cycle keeps it pending
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pedReg <= 1'b0;
        end else begin
            pedReg <= (pedReg & ~bus.pedAck) | (|pedEff);
        end
    end

    assign bus.pedSignal = pedReg;

    emgState_e            state;
    logic [HOLD_W-1:0]    holdCnt;
    logic [NUM_LANES-1:0] emgLaneReg;
    logic                 emgSignalReg;
    logic [NUM_LANES-1:0] lowestReq;
    logic                 grantedReq;

    // Isolate the lowest set request bit so the grant is always one-hot
    assign lowestReq  = emgEff & (~emgEff + NUM_LANES'(1));
    assign grantedReq = |(emgEff & emgLaneReg);

    // Emergency arbitration: grant lowest lane, hold EMG_HOLD cycles after release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            holdCnt      <= '0;
            emgLaneReg   <= '0;
            emgSignalReg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|emgEff) begin
                        emgLaneReg   <= lowestReq;
                        emgSignalReg <= 1'b1;
                        state        <= GRANT;
                    end
                end
                GRANT: begin
                    if (!grantedReq) begin
                        holdCnt <= HOLD_W'(EMG_HOLD - 1);
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (grantedReq) begin
                        state <= GRANT;
                    end else if (holdCnt == '0) begin
                        emgLaneReg   <= '0;
                        emgSignalReg <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        holdCnt <= holdCnt - HOLD_W'(1);
                    end
                end
                default: begin
                    emgLaneReg   <= '0;
                    emgSignalReg <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign bus.emgSignal = emgSignalReg;
    assign bus.emgLane   = emgLaneReg;
endmodule

// File: tb/tb_lane_sensor_hub.sv
// tb/tb_lane_sensor_hub.sv - directed table and sequence checks for lane_sensor_hub
module tb_lane_sensor_hub;
    import traffic_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    lane_sensor_hub_if #(.NUM_LANES(8), .CNT_W(8)) hubIf ();

    lane_sensor_hub dut (
        .clk (clk),
        .rst (rst),
        .bus (hubIf.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0]  arrive;
        logic [7:0]  depart;
        logic [7:0]  pedButton;
        logic        pedAck;
        logic [63:0] expCounts;
        logic        expPed;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clearInputs();
        hubIf.arrive    = '0;
        hubIf.depart    = '0;
        hubIf.pedButton = '0;
        hubIf.pedAck    = 1'b0;
        hubIf.emgReq    = '0;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic chkEmg(input string name, input logic expSig, input logic [7:0] expLane);
        chk({name, "_sig"}, 64'(hubIf.emgSignal), 64'(expSig));
        chk({name, "_lane"}, 64'(hubIf.emgLane), 64'(expLane));
        chk({name, "_onehot0"}, 64'($onehot0(hubIf.emgLane)), 64'd1);
    endtask

    function automatic logic [7:0] laneOf(input logic [63:0] counts, input int idx);
        return counts[idx*8 +: 8];
    endfunction

    initial begin
        errors = 0;
        checks = 0;

        vecs[0] = '{8'hFF, 8'h00, 8'h00, 1'b0, 64'h0101010101010101, 1'b0};
        vecs[1] = '{8'h0F, 8'hF0, 8'h00, 1'b0, 64'h0000000002020202, 1'b0};
        vecs[2] = '{8'h01, 8'h01, 8'h20, 1'b0, 64'h0000000002020202, 1'b1};
        vecs[3] = '{8'h00, 8'h0F, 8'h00, 1'b0, 64'h0000000001010101, 1'b1};
        vecs[4] = '{8'h00, 8'h03, 8'h04, 1'b1, 64'h0000000001010000, 1'b1};
        vecs[5] = '{8'h00, 8'h03, 8'h00, 1'b1, 64'h0000000001010000, 1'b0};
        vecs[6] = '{8'h80, 8'h00, 8'h00, 1'b1, 64'h0100000001010000, 1'b0};
        vecs[7] = '{8'h80, 8'h04, 8'h00, 1'b0, 64'h0200000001000000, 1'b0};

        clearInputs();
        rst = 1'b0;
        #3;
        chk("reset_counts", hubIf.laneCounts, 64'h0);
        chk("reset_ped", 64'(hubIf.pedSignal), 64'd0);
        chkEmg("reset_emg", 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b1;

`ifdef SENSOR_SYNC_EN
        hubIf.arrive[LANE_N2] = 1'b1;
        step();
        step();
        chk("sync_n2_lat2", 64'(laneOf(hubIf.laneCounts, LANE_N2)), 64'd0);
        step();
        chk("sync_n2_lat3", 64'(laneOf(hubIf.laneCounts, LANE_N2)), 64'd1);
        step();
        hubIf.arrive[LANE_N2] = 1'b0;
        repeat (5) step();
        chk("sync_n2_once", 64'(laneOf(hubIf.laneCounts, LANE_N2)), 64'd1);
`else
        for (int i = 0; i < 8; i++) begin
            hubIf.arrive    = vecs[i].arrive;
            hubIf.depart    = vecs[i].depart;
            hubIf.pedButton = vecs[i].pedButton;
            hubIf.pedAck    = vecs[i].pedAck;
            step();
            chk($sformatf("vec%0d_counts", i), hubIf.laneCounts, vecs[i].expCounts);
            chk($sformatf("vec%0d_ped", i), 64'(hubIf.pedSignal), 64'(vecs[i].expPed));
        end

        // Reset mid-count, mid-grant and with a pending pedestrian request
        doReset();
        hubIf.arrive[LANE_N1] = 1'b1;
        hubIf.pedButton[5]    = 1'b1;
        hubIf.emgReq          = 8'h01;
        step();
        hubIf.pedButton = '0;
        repeat (4) step();
        chk("midrst_pre_n1", hubIf.laneCounts, 64'h0000000000000500);
        chk("midrst_pre_ped", 64'(hubIf.pedSignal), 64'd1);
        chkEmg("midrst_pre_emg", 1'b1, 8'h01);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_counts", hubIf.laneCounts, 64'h0);
        chk("midrst_ped", 64'(hubIf.pedSignal), 64'd0);
        chkEmg("midrst_emg", 1'b0, 8'h00);
        clearInputs();
        @(negedge clk);
        rst = 1'b1;

        // Saturation at 255 and floor at 0
        doReset();
        hubIf.arrive[LANE_W1] = 1'b1;
        repeat (260) step();
        chk("sat_w1_255", 64'(laneOf(hubIf.laneCounts, LANE_W1)), 64'd255);
        hubIf.depart[LANE_W1] = 1'b1;
        step();
        chk("sat_both_255", 64'(laneOf(hubIf.laneCounts, LANE_W1)), 64'd255);
        hubIf.arrive[LANE_W1] = 1'b0;
        step();
        chk("sat_dep_254", 64'(laneOf(hubIf.laneCounts, LANE_W1)), 64'd254);
        hubIf.depart = 8'h01;
        step();
        chk("floor_n2_0", hubIf.laneCounts, 64'hFE00000000000000);

        // Emergency priority and hold timing
        doReset();
        hubIf.emgReq = 8'b00001010;
        step();
        chkEmg("emg_grant", 1'b1, 8'b00000010);
        hubIf.emgReq = 8'b00001000;
        for (int i = 0; i < 4; i++) begin
            step();
            chkEmg($sformatf("emg_hold%0d", i), 1'b1, 8'b00000010);
        end
        step();
        chkEmg("emg_release", 1'b0, 8'h00);
        step();
        chkEmg("emg_next", 1'b1, 8'b00001000);

        // Re-assert during hold returns to grant; hold restarts on next drop
        hubIf.emgReq = 8'h00;
        step();
        chkEmg("rea_hold1", 1'b1, 8'b00001000);
        hubIf.emgReq = 8'b00001000;
        step();
        chkEmg("rea_grant", 1'b1, 8'b00001000);
        repeat (3) step();
        chkEmg("rea_stay", 1'b1, 8'b00001000);
        hubIf.emgReq = 8'b00000001;
        for (int i = 0; i < 4; i++) begin
            step();
            chkEmg($sformatf("rea_hold%0d", i), 1'b1, 8'b00001000);
        end
        step();
        chkEmg("rea_release", 1'b0, 8'h00);
        step();
        chkEmg("rea_other", 1'b1, 8'b00000001);

        // Pedestrian handshake
        doReset();
        hubIf.pedButton[5] = 1'b1;
        step();
        hubIf.pedButton = '0;
        repeat (10) step();
        chk("ped_held", 64'(hubIf.pedSignal), 64'd1);
        hubIf.pedAck       = 1'b1;
        hubIf.pedButton[2] = 1'b1;
        step();
        chk("ped_ack_press", 64'(hubIf.pedSignal), 64'd1);
        hubIf.pedButton = '0;
        hubIf.pedAck    = 1'b0;
        repeat (2) step();
        chk("ped_still", 64'(hubIf.pedSignal), 64'd1);
        hubIf.pedAck = 1'b1;
        step();
        chk("ped_cleared", 64'(hubIf.pedSignal), 64'd0);
        hubIf.pedAck = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lane_sensor_hub.md
Name: lane_sensor_hub

Overview:
- Upstream stage of the intersection controller (Breadboard); replaces the bench-driven lane counts, pedestrian signal and emergency signals with registered, sensor-derived values.
- Counts vehicles per lane from arrive/depart sensor pulses.
- Latches pedestrian button presses until the controller acknowledges them.
- Arbitrates emergency-vehicle requests into a single one-hot emergency lane.

Parameters:
- NUM_LANES, 8, number of lanes (fixed lane order below).
- CNT_W, 8, width of each per-lane vehicle counter.
- EMG_HOLD, 4, cycles the emergency grant is held after the granted request drops.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- arrive  input  NUM_LANES  per-lane vehicle-arrival pulse.
- depart  input  NUM_LANES  per-lane vehicle-departure pulse.
- pedButton  input  NUM_LANES  per-crosswalk button.
- pedAck  input  1  controller has served the pedestrian request.
- emgReq  input  NUM_LANES  per-lane emergency-vehicle request, level.
- laneCounts  output  NUM_LANES*CNT_W  packed {w1,w2,s1,s2,e1,e2,n1,n2}; lane index 0=n2, 1=n1, 2=e2, 3=e1, 4=s2, 5=s1, 6=w2, 7=w1.
- pedSignal  output  1  pending pedestrian request.
- emgSignal  output  1  emergency active.
- emgLane  output  NUM_LANES  one-hot granted emergency lane, 0 when idle.

Behaviour:
- Reset: all outputs registered; on rst low, immediately clear laneCounts, pedSignal, emgSignal and emgLane to 0, set the FSM to IDLE and clear the hold counter.
  - Applies mid-operation too, including mid-GRANT or mid-HOLD.
- Counters: one per lane, updated each clk, result visible 1 cycle after the sampled pulse.
  - arrive only: +1, saturating at 2^CNT_W-1 (255 stays 255).
  - depart only: -1, floored at 0 (0 stays 0).
  - arrive and depart in the same cycle: unchanged, including at 0 and at 255.
  - Lanes are independent; all 8 may change in the same cycle.
- Pedestrian handshake:
  - pedSignal sets on any pedButton bit high; it stays 1 until pedAck is sampled high, then clears next cycle.
  - pedAck and a new press in the same cycle: pedSignal stays 1, so the new request is not lost.
  - pedAck while pedSignal=0: ignored.
- Emergency FSM, states IDLE, GRANT, HOLD:
  - IDLE: if emgReq≠0, grant the lowest-index asserted lane; next cycle emgLane=one-hot(that lane), emgSignal=1, state GRANT.
  - GRANT: stay while emgReq[granted]=1; requests on other lanes are ignored. When it drops, load hold counter with EMG_HOLD-1 and go to HOLD; emgSignal and emgLane unchanged.
  - HOLD:
    - emgReq[granted] re-asserts: back to GRANT with the same lane.
    - counter=0: go to IDLE, clearing emgSignal and emgLane in the same transition.
    - otherwise decrement.
    - Other lanes wait until IDLE.
  - Grant-to-release: emgSignal stays high exactly EMG_HOLD cycles after the cycle in which the request is seen low.
  - emgLane is always one-hot or zero, never multi-hot.

Optional Feature:
- Macro SENSOR_SYNC_EN.
- Defined:
  - arrive, depart, pedButton and emgReq each pass through a 2-flop synchronizer.
  - arrive, depart and pedButton are then rising-edge detected, so a held level counts once.
  - Adds 2 cycles of input-to-output latency; emgReq stays level-sensitive after synchronizing.
- Undefined: inputs are treated as synchronous. arrive/depart count on every cycle they are high; a 3-cycle-high arrive adds 3.

Decomposition:
- Shared package traffic_pkg holds:
  - NUM_LANES and CNT_W defaults.
  - Lane index constants LANE_N2..LANE_W1 (0..7).
  - Emergency state enum {IDLE, GRANT, HOLD}.
  - Breadboard imports the same package for lane order.
- One natural sub-module: lane_counter, a saturating up/down counter with width CNT_W, instantiated NUM_LANES times via generate.

Test Plan:
- Reset mid-count: arrive[1] for 5 cycles (n1=5), then pull rst low mid-cycle -> laneCounts=0 immediately, emgSignal=0, pedSignal=0.
- Saturation: 260 arrive[7] pulses -> w1=255. Then arrive+depart together -> stays 255. Then 1 depart -> 254. Depart on lane 0 at 0 -> stays 0.
- Emergency priority: emgReq=8'b00001010 -> next cycle emgLane=8'b00000010, emgSignal=1. Drop bit 1, keep bit 3 -> emgSignal high 4 more cycles, then IDLE, then emgLane=8'b00001000 one cycle later.
- Hold re-assert: granted lane 3 drops, re-asserts on the 2nd HOLD cycle -> state GRANT, emgLane unchanged, hold restarts on the next drop.
- Pedestrian handshake: pedButton[5] 1 cycle -> pedSignal=1 held through 10 idle cycles. pedAck and pedButton[2] in the same cycle -> pedSignal stays 1. A lone pedAck later -> pedSignal=0.
- SENSOR_SYNC_EN build: arrive[0] held high 4 cycles -> n2 increments by exactly 1, visible 3 cycles after the rising edge.
